// File: rtl/psum_ofifo_pkg.sv
// Shared defaults for the psum output path: lane count, word width, FIFO depth
// and a constant-foldable ceil-log2 used to size the column FIFO pointers.
package psum_ofifo_pkg;

  localparam int COL         = 8;
  localparam int PSUM_BW     = 16;
  localparam int OFIFO_DEPTH = 64;

  function automatic int clog2(input int value);
    int res;
    res = 0;
    while ((1 << res) < value) res++;
    return res;
  endfunction

endpackage

// File: rtl/psum_col_fifo.sv
// One column lane of the output collector: circular buffer with async read and
// pointers one bit wider than the address, so the extra MSB separates full from empty.
module psum_col_fifo
  import psum_ofifo_pkg::*;
#(
  parameter int psum_bw = PSUM_BW,
  parameter int depth   = OFIFO_DEPTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr,
  input  logic               rd,
  input  logic [psum_bw-1:0] din,
  output logic [psum_bw-1:0] dout,
  output logic               empty,
  output logic               full
);

  localparam int AW = clog2(depth);

  logic [AW:0]        wp_q, wp_d;
  logic [AW:0]        rp_q, rp_d;
  logic [psum_bw-1:0] mem_q [depth];
  logic               push;

  assign empty = (wp_q == rp_q);
  assign full  = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
  assign dout  = mem_q[rp_q[AW-1:0]];

  // rd is only raised by the top when every lane holds a word, so a pop on a
  // full lane frees the slot the simultaneous push lands in.
  assign push = wr && (!full || rd);

  always_comb begin
    wp_d = wp_q;
    rp_d = rp_q;
    if (push) wp_d = wp_q + {{AW{1'b0}}, 1'b1};
    if (rd)   rp_d = rp_q + {{AW{1'b0}}, 1'b1};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wp_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/psum_ofifo.sv
// Re-aligns skewed MAC column outputs into full rows for SRAM writeback.
// Build option PSUM_OFIFO_RELU_EN: clamp negative popped words to zero.
module psum_ofifo
  import psum_ofifo_pkg::*;
#(
  parameter int col     = COL,
  parameter int psum_bw = PSUM_BW,
  parameter int depth   = OFIFO_DEPTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [col-1:0]         wr,
  input  logic [psum_bw*col-1:0] in,
  input  logic                   rd,
  output logic [psum_bw*col-1:0] out,
  output logic                   out_valid,
  output logic                   o_ready,
  output logic                   full,
  output logic                   overflow
);

  logic [col-1:0]         empty_c;
  logic [col-1:0]         full_c;
  logic [psum_bw*col-1:0] row;
  logic                   pop;
  logic                   drop;

  logic [psum_bw*col-1:0] out_q, out_d;
  logic                   vld_q;
  logic                   ovf_q;

  function automatic logic [psum_bw-1:0] relu(input logic signed [psum_bw-1:0] w);
`ifdef PSUM_OFIFO_RELU_EN
    return (w < 0) ? '0 : w;
`else
    return w;
`endif
  endfunction

  assign o_ready = &(~empty_c);
  assign full    = |full_c;
  assign pop     = rd && o_ready;
  // A push into a full lane survives only if this edge also pops.
  assign drop    = |(wr & full_c & ~{col{pop}});

  for (genvar g = 0; g < col; g++) begin : g_lane
    psum_col_fifo #(
      .psum_bw (psum_bw),
      .depth   (depth)
    ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .wr    (wr[g]),
      .rd    (pop),
      .din   (in[g*psum_bw +: psum_bw]),
      .dout  (row[g*psum_bw +: psum_bw]),
      .empty (empty_c[g]),
      .full  (full_c[g])
    );
  end

  always_comb begin
    out_d = out_q;
    if (pop) begin
      for (int i = 0; i < col; i++) out_d[i*psum_bw +: psum_bw] = relu(row[i*psum_bw +: psum_bw]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_q <= '0;
      vld_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      out_q <= out_d;
      vld_q <= pop;
      ovf_q <= ovf_q | drop;
    end
  end

  assign out       = out_q;
  assign out_valid = vld_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_psum_ofifo.sv
// Directed-plus-random bench for psum_ofifo against a per-column queue model.
module tb_psum_ofifo;

  localparam int NC    = 8;
  localparam int W     = 16;
  localparam int DEPTH = 64;

  logic              clk;
  logic              reset;
  logic [NC-1:0]     wr;
  logic [W*NC-1:0]   din;
  logic              rd;
  logic [W*NC-1:0]   dout;
  logic              out_valid;
  logic              o_ready;
  logic              full;
  logic              overflow;

  int checks = 0;
  int errors = 0;

  logic [W-1:0]    q [NC][$];
  logic [W*NC-1:0] out_exp;
  logic            vld_exp;
  logic            ov_exp;
  logic [W*NC-1:0] rows [100];

  psum_ofifo dut (
    .clk       (clk),
    .reset     (reset),
    .wr        (wr),
    .in        (din),
    .rd        (rd),
    .out       (dout),
    .out_valid (out_valid),
    .o_ready   (o_ready),
    .full      (full),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] relu_m(input logic [W-1:0] w);
`ifdef PSUM_OFIFO_RELU_EN
    return w[W-1] ? '0 : w;
`else
    return w;
`endif
  endfunction

  function automatic logic [W*NC-1:0] rnd_row();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string tag, input logic [W*NC-1:0] obs, input logic [W*NC-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive, check flags before the edge, advance model, check registers after.
  task automatic step(input logic [NC-1:0] w, input logic [W*NC-1:0] d, input logic r);
    bit rdy, ful, pop;
    wr = w; din = d; rd = r;
    #1;
    rdy = 1'b1; ful = 1'b0;
    for (int i = 0; i < NC; i++) begin
      if (q[i].size() == 0) rdy = 1'b0;
      if (q[i].size() == DEPTH) ful = 1'b1;
    end
    chk("o_ready", o_ready, rdy);
    chk("full", full, ful);
    @(posedge clk);
    pop = r && rdy;
    vld_exp = pop;
    if (pop) begin
      for (int i = 0; i < NC; i++) out_exp[i*W +: W] = relu_m(q[i].pop_front());
    end
    for (int i = 0; i < NC; i++) begin
      if (w[i]) begin
        if (q[i].size() < DEPTH) q[i].push_back(d[i*W +: W]);
        else ov_exp = 1'b1;
      end
    end
    #1;
    chk("out_valid", out_valid, vld_exp);
    chk("out", dout, out_exp);
    chk("overflow", overflow, ov_exp);
  endtask

  task automatic do_reset();
    wr = '0; din = '0; rd = 1'b0; reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < NC; i++) q[i].delete();
    out_exp = '0; vld_exp = 1'b0; ov_exp = 1'b0;
    chk("rst_o_ready", o_ready, 1'b0);
    chk("rst_full", full, 1'b0);
    chk("rst_out", dout, '0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_overflow", overflow, 1'b0);
  endtask

  initial begin
    logic [W*NC-1:0] d;
    logic [NC-1:0]   w;
    reset = 1'b1; wr = '0; din = '0; rd = 1'b0;
    @(posedge clk);
    #1;

    // 1: empty after reset, pops ignored
    do_reset();
    step('0, '0, 1'b1);
    step('0, '0, 1'b1);

    // 2: skewed one-hot fill, then one pop
    for (int i = 0; i < NC; i++) begin
      d = '0;
      d[i*W +: W] = 16'h0100 + W'(i);
      step(NC'(1 << i), d, 1'b0);
    end
    step('0, '0, 1'b1);
    for (int i = 0; i < NC; i++) chk("skew_lane", dout[i*W +: W], 16'h0100 + W'(i));
    step('0, '0, 1'b0);

    // 3: 100 rows, column i delayed by i cycles, rd held high
    for (int k = 0; k < 100; k++) rows[k] = rnd_row();
    for (int t = 0; t < 100 + NC + 2; t++) begin
      w = '0; d = '0;
      for (int i = 0; i < NC; i++) begin
        if (t - i >= 0 && t - i < 100) begin
          w[i] = 1'b1;
          d[i*W +: W] = rows[t-i][i*W +: W];
        end
      end
      step(w, d, 1'b1);
    end
    chk("stream_overflow", overflow, 1'b0);

    // 4: fill col3 alone, overflow on the 65th push, then fill others and drain
    do_reset();
    for (int k = 0; k < DEPTH; k++) step(8'h08, rnd_row(), 1'b0);
    step(8'h08, rnd_row(), 1'b0);
    chk("col3_overflow", overflow, 1'b1);
    for (int k = 0; k < DEPTH; k++) step(8'hF7, rnd_row(), 1'b0);
    for (int k = 0; k < DEPTH; k++) step('0, '0, 1'b1);
    step('0, '0, 1'b1);

    // 5: all lanes full, push and pop together, then drain
    do_reset();
    for (int k = 0; k < DEPTH; k++) step('1, rnd_row(), 1'b0);
    step('1, rnd_row(), 1'b1);
    step('0, '0, 1'b0);
    chk("fullpop_full", full, 1'b1);
    for (int k = 0; k < DEPTH; k++) step('0, '0, 1'b1);
    step('0, '0, 1'b0);

    // 6: reset while half full with overflow set and a row on out
    do_reset();
    for (int k = 0; k < DEPTH / 2; k++) step('1, rnd_row(), 1'b0);
    for (int k = 0; k < DEPTH / 2 + 1; k++) step(8'h01, rnd_row(), 1'b0);
    step('0, '0, 1'b1);
    do_reset();
    d = rnd_row();
    d[W-1:0]  = 16'hFFF0;
    d[2*W-1:W] = 16'h0010;
    step('1, d, 1'b0);
    step('0, '0, 1'b1);
`ifdef PSUM_OFIFO_RELU_EN
    chk("relu_neg", dout[W-1:0], 16'h0000);
`else
    chk("relu_neg", dout[W-1:0], 16'hFFF0);
`endif
    chk("relu_pos", dout[2*W-1:W], 16'h0010);
    step('0, '0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
